// File: rtl/pf_io_dly_ctrl.sv
// pf_io_dly_ctrl
// Sequences the dynamic input delay line of a PF_IO receive buffer.
// Tap requests (SET / INC / DEC / LOAD) arrive over a valid/ready handshake and
// are turned into DELAY_LINE_MOVE / DIRECTION / LOAD pulses while the current
// tap is tracked locally and out-of-range conditions are reported on ERR.
//
// Ports
//   CLK, RESETN               clock (rising edge), async active-low reset
//   REQ_VALID/READY           request handshake, accepted when both high
//   REQ_OP                    00 SET, 01 INC, 10 DEC, 11 LOAD
//   REQ_TAP                   target tap for SET
//   DONE, ERR                 one-cycle completion pulse, ERR valid with DONE
//   CUR_TAP                   tracked tap
//   DELAY_LINE_MOVE/DIRECTION step pulse and direction (1 = increment)
//   DELAY_LINE_LOAD           reload to static tap
//   DELAY_LINE_OUT_OF_RANGE   end-stop indication from PF_IO
//
// Build option: PF_IO_DLY_CTRL_SYNC_OOR_EN adds a 2-flop synchronizer on
// DELAY_LINE_OUT_OF_RANGE and stretches each gap by two cycles to cover it.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_INIT  | first cycle after reset, launches the reload
// ST_IDLE  | ready for a request
// ST_CHECK | range check, step count and direction
// ST_MOVE  | MOVE pulse high
// ST_GAP   | idle gap after a step, OUT_OF_RANGE sampled on its last cycle
// ST_LOAD  | LOAD held high (after reset or on a LOAD request)
// ST_FIN   | DONE pulse with ERR

module pf_io_dly_ctrl #(
    parameter int NUM_TAPS    = 128,
    parameter int TAP_W       = 7,
    parameter int INIT_TAP    = 0,
    parameter int MOVE_GAP    = 2,
    parameter int LOAD_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [1:0]       REQ_OP,
    input  logic [TAP_W-1:0] REQ_TAP,
    output logic             DONE,
    output logic             ERR,
    output logic [TAP_W-1:0] CUR_TAP,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    output logic             DELAY_LINE_LOAD,
    input  logic             DELAY_LINE_OUT_OF_RANGE
);

    localparam logic [1:0] OP_SET  = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    localparam logic [TAP_W-1:0] TAP_ONE  = TAP_W'(1);
    localparam logic [TAP_W-1:0] TAP_ZERO = TAP_W'(0);
    localparam logic [TAP_W-1:0] TAP_MAX  = TAP_W'(NUM_TAPS - 1);
    localparam logic [TAP_W-1:0] TAP_INIT = TAP_W'(INIT_TAP);

    typedef enum logic [2:0] {
        ST_INIT, ST_IDLE, ST_CHECK, ST_MOVE, ST_GAP, ST_LOAD, ST_FIN
    } state_t;

    logic oor_s;

`ifdef PF_IO_DLY_CTRL_SYNC_OOR_EN
    localparam int GAP_LEN = MOVE_GAP + 2;
    logic [1:0] oor_sync;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) oor_sync <= 2'b00;
        else         oor_sync <= {oor_sync[0], DELAY_LINE_OUT_OF_RANGE};
    end
    assign oor_s = oor_sync[1];
`else
    localparam int GAP_LEN = MOVE_GAP;
    assign oor_s = DELAY_LINE_OUT_OF_RANGE;
`endif

    state_t           state;
    logic [1:0]       op_q;
    logic [TAP_W-1:0] tap_q;
    logic [TAP_W-1:0] steps;
    logic [15:0]      cnt;
    logic             from_init;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state                <= ST_INIT;
            op_q                 <= OP_SET;
            tap_q                <= TAP_ZERO;
            steps                <= TAP_ZERO;
            cnt                  <= 16'd0;
            from_init            <= 1'b0;
            REQ_READY            <= 1'b0;
            DONE                 <= 1'b0;
            ERR                  <= 1'b0;
            CUR_TAP              <= TAP_INIT;
            DELAY_LINE_MOVE      <= 1'b0;
            DELAY_LINE_DIRECTION <= 1'b0;
            DELAY_LINE_LOAD      <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_INIT: begin
                    DELAY_LINE_LOAD <= 1'b1;
                    cnt             <= 16'(LOAD_CYCLES - 1);
                    from_init       <= 1'b1;
                    state           <= ST_LOAD;
                end
                ST_IDLE: begin
                    if (REQ_VALID) begin
                        op_q      <= REQ_OP;
                        tap_q     <= REQ_TAP;
                        REQ_READY <= 1'b0;
                        state     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    case (op_q)
                        OP_SET: begin
                            if (32'(tap_q) >= NUM_TAPS) begin
                                DONE  <= 1'b1;
                                ERR   <= 1'b1;
                                state <= ST_FIN;
                            end else if (tap_q == CUR_TAP) begin
                                DONE  <= 1'b1;
                                ERR   <= 1'b0;
                                state <= ST_FIN;
                            end else begin
                                DELAY_LINE_DIRECTION <= (tap_q > CUR_TAP);
                                steps <= (tap_q > CUR_TAP) ? (tap_q - CUR_TAP) : (CUR_TAP - tap_q);
                                DELAY_LINE_MOVE      <= 1'b1;
                                state                <= ST_MOVE;
                            end
                        end
                        OP_INC, OP_DEC: begin
                            if ((op_q == OP_INC && CUR_TAP == TAP_MAX) ||
                                (op_q == OP_DEC && CUR_TAP == TAP_ZERO)) begin
                                DONE  <= 1'b1;
                                ERR   <= 1'b1;
                                state <= ST_FIN;
                            end else begin
                                DELAY_LINE_DIRECTION <= (op_q == OP_INC);
                                steps                <= TAP_ONE;
                                DELAY_LINE_MOVE      <= 1'b1;
                                state                <= ST_MOVE;
                            end
                        end
                        default: begin
                            DELAY_LINE_LOAD <= 1'b1;
                            cnt             <= 16'(LOAD_CYCLES - 1);
                            from_init       <= 1'b0;
                            state           <= ST_LOAD;
                        end
                    endcase
                end
                ST_MOVE: begin
                    DELAY_LINE_MOVE <= 1'b0;
                    cnt             <= 16'(GAP_LEN - 1);
                    state           <= ST_GAP;
                end
                ST_GAP: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else if (oor_s) begin
                        // End stop hit: the step just issued did not take effect.
                        DONE  <= 1'b1;
                        ERR   <= 1'b1;
                        state <= ST_FIN;
                    end else begin
                        CUR_TAP <= DELAY_LINE_DIRECTION ? (CUR_TAP + TAP_ONE) : (CUR_TAP - TAP_ONE);
                        steps   <= steps - TAP_ONE;
                        if (steps == TAP_ONE) begin
                            DONE  <= 1'b1;
                            ERR   <= 1'b0;
                            state <= ST_FIN;
                        end else begin
                            DELAY_LINE_MOVE <= 1'b1;
                            state           <= ST_MOVE;
                        end
                    end
                end
                ST_LOAD: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        DELAY_LINE_LOAD <= 1'b0;
                        CUR_TAP         <= TAP_INIT;
                        if (from_init) begin
                            // Power-up reload is silent: straight to IDLE, no DONE.
                            REQ_READY <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            DONE  <= 1'b1;
                            ERR   <= 1'b0;
                            state <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    REQ_READY <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_pf_io_dly_ctrl.sv
// Bench for pf_io_dly_ctrl: directed scenarios plus randomized requests,
// each checked against a request-level model of tap position and timing.
module tb_pf_io_dly_ctrl;

    localparam int NUM_TAPS    = 128;
    localparam int TAP_W       = 7;
    localparam int INIT_TAP    = 0;
    localparam int MOVE_GAP    = 2;
    localparam int LOAD_CYCLES = 2;
`ifdef PF_IO_DLY_CTRL_SYNC_OOR_EN
    localparam int STEP = MOVE_GAP + 3;
`else
    localparam int STEP = MOVE_GAP + 1;
`endif

    logic             clk_sys = 1'b0;
    logic             rst_b   = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op  = 2'b00;
    logic [TAP_W-1:0] req_tap = '0;
    logic             done;
    logic             err;
    logic [TAP_W-1:0] cur_tap;
    logic             dl_move;
    logic             dl_dir;
    logic             dl_load;
    logic             dl_oor = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int m_tap    = INIT_TAP;

    always #5 clk_sys = ~clk_sys;

    pf_io_dly_ctrl #(
        .NUM_TAPS(NUM_TAPS), .TAP_W(TAP_W), .INIT_TAP(INIT_TAP),
        .MOVE_GAP(MOVE_GAP), .LOAD_CYCLES(LOAD_CYCLES)
    ) dut (
        .CLK                    (clk_sys),
        .RESETN                 (rst_b),
        .REQ_VALID              (req_valid),
        .REQ_READY              (req_ready),
        .REQ_OP                 (req_op),
        .REQ_TAP                (req_tap),
        .DONE                   (done),
        .ERR                    (err),
        .CUR_TAP                (cur_tap),
        .DELAY_LINE_MOVE        (dl_move),
        .DELAY_LINE_DIRECTION   (dl_dir),
        .DELAY_LINE_LOAD        (dl_load),
        .DELAY_LINE_OUT_OF_RANGE(dl_oor)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called right after reset release: reload must last LOAD_CYCLES, READY
    // follows immediately, no DONE.
    task automatic run_init(input string tag);
        int c = 0, loads = 0, last_load = -1, dones = 0;
        while (!req_ready && c < 20) begin
            @(negedge clk_sys);
            c++;
            if (dl_load) begin loads++; last_load = c; end
            if (done) dones++;
        end
        check_val({tag, "_ready"}, 32'(req_ready), 1);
        check_val({tag, "_loads"}, loads, LOAD_CYCLES);
        check_val({tag, "_ready_after_load"}, last_load, c - 1);
        check_val({tag, "_no_done"}, dones, 0);
        check_val({tag, "_tap"}, 32'(cur_tap), INIT_TAP);
        m_tap = INIT_TAP;
    endtask

    // oor_pick > 0 raises OUT_OF_RANGE ahead of step ((oor_pick-1) % N)+1.
    task automatic do_req(input logic [1:0] op, input int tap, input int oor_pick, input string tag);
        bit rej = 0, dir = 0, is_ld = 0, done_seen = 0;
        int n = 0, k = 0, exp_done, exp_err, exp_moves, exp_tap, exp_loads;
        int w = 0, c = 0, moves = 0, loads = 0, budget;

        case (op)
            2'b00: if (tap >= NUM_TAPS) rej = 1;
                   else begin n = tap - m_tap; dir = (n > 0); if (n < 0) n = -n; end
            2'b01: if (m_tap == NUM_TAPS - 1) rej = 1; else begin n = 1; dir = 1; end
            2'b10: if (m_tap == 0) rej = 1; else begin n = 1; dir = 0; end
            default: is_ld = 1;
        endcase
        if (!rej && !is_ld && oor_pick > 0 && n > 0) k = ((oor_pick - 1) % n) + 1;

        exp_loads = 0;
        if (is_ld) begin
            exp_done = 2 + LOAD_CYCLES; exp_err = 0; exp_moves = 0;
            exp_tap = INIT_TAP; exp_loads = LOAD_CYCLES;
        end else if (rej || n == 0) begin
            exp_done = 2; exp_err = rej ? 1 : 0; exp_moves = 0; exp_tap = m_tap;
        end else if (k > 0) begin
            exp_done = 2 + k * STEP; exp_err = 1; exp_moves = k;
            exp_tap = dir ? m_tap + (k - 1) : m_tap - (k - 1);
        end else begin
            exp_done = 2 + n * STEP; exp_err = 0; exp_moves = n;
            exp_tap = dir ? m_tap + n : m_tap - n;
        end

        while (!req_ready && w < 50) begin @(negedge clk_sys); w++; end
        if (!req_ready) begin
            check_val({tag, "_ready_timeout"}, 0, 1);
            return;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_tap   = TAP_W'(tap);
        budget    = exp_done + 20;
        while (!done_seen && c < budget) begin
            @(negedge clk_sys);
            c++;
            if (c == 1) begin
                // VALID stays high with junk while busy; it must be ignored.
                check_val({tag, "_busy_ready"}, 32'(req_ready), 0);
                req_op  = 2'($urandom);
                req_tap = TAP_W'($urandom);
            end
            if (dl_move) begin
                check_val({tag, "_move_cyc"}, c, 2 + moves * STEP);
                check_val({tag, "_move_dir"}, 32'(dl_dir), 32'(dir));
                moves++;
                if (moves == k) dl_oor = 1'b1;
            end
            if (dl_load) loads++;
            if (done) begin
                done_seen = 1;
                req_valid = 1'b0;
                dl_oor    = 1'b0;
                check_val({tag, "_done_cyc"}, c, exp_done);
                check_val({tag, "_err"}, 32'(err), exp_err);
                check_val({tag, "_tap"}, 32'(cur_tap), exp_tap);
            end
        end
        if (!done_seen) begin
            check_val({tag, "_done_timeout"}, 0, 1);
            req_valid = 1'b0;
            dl_oor    = 1'b0;
        end
        check_val({tag, "_moves"}, moves, exp_moves);
        check_val({tag, "_loads"}, loads, exp_loads);
        m_tap = exp_tap;
    endtask

    initial begin
        int c, moves;

        // Reset values while RESETN is low.
        repeat (3) @(negedge clk_sys);
        check_val("rst_move",  32'(dl_move),  0);
        check_val("rst_dir",   32'(dl_dir),   0);
        check_val("rst_load",  32'(dl_load),  0);
        check_val("rst_ready", 32'(req_ready), 0);
        check_val("rst_done",  32'(done),     0);
        check_val("rst_err",   32'(err),      0);
        check_val("rst_tap",   32'(cur_tap),  INIT_TAP);
        rst_b = 1'b1;
        run_init("init");

        do_req(2'b00, 5,   0, "set5");
        do_req(2'b10, 0,   0, "dec");
        do_req(2'b00, 4,   0, "set_same");
        do_req(2'b11, 0,   0, "load");
        do_req(2'b10, 0,   0, "dec_at0");
        do_req(2'b00, 127, 0, "set127");
        do_req(2'b01, 0,   0, "inc_at_max");
        do_req(2'b10, 0,   0, "dec_from_max");
        do_req(2'b11, 0,   0, "load2");
        do_req(2'b00, 10,  4, "set10_oor");

        for (int i = 0; i < 60; i++) begin
            int pick;
            repeat ($urandom_range(0, 2)) @(negedge clk_sys);
            pick = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 200)) : 0;
            do_req(2'($urandom_range(0, 3)), int'($urandom_range(0, NUM_TAPS - 1)), pick, "rnd");
        end

        // Reset in the middle of a multi-step SET.
        do_req(2'b11, 0, 0, "load3");
        @(negedge clk_sys);
        req_valid = 1'b1; req_op = 2'b00; req_tap = TAP_W'(20);
        c = 0; moves = 0;
        while (moves < 3 && c < 100) begin
            @(negedge clk_sys);
            c++;
            if (c == 1) req_valid = 1'b0;
            if (dl_move) moves++;
        end
        check_val("midrst_reached_step3", moves, 3);
        rst_b = 1'b0;
        #1;
        check_val("midrst_move",  32'(dl_move),  0);
        check_val("midrst_ready", 32'(req_ready), 0);
        check_val("midrst_tap",   32'(cur_tap),  INIT_TAP);
        c = 0;
        repeat (3) begin
            @(negedge clk_sys);
            if (done) c++;
        end
        check_val("midrst_no_done", c, 0);
        rst_b = 1'b1;
        run_init("reinit");
        do_req(2'b00, 5, 0, "post_rst_set5");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
